// File: rtl/calendar_date_counter.sv
// Month/day calendar counter with tick divider, registered BCD outputs.
// Optional alarm compare built only when DATE_ALARM_EN is defined.
//
// Ports:
//   ADC_CLK_10              clock
//   rst_n                   async reset, active low
//   leap                    1 = February has 29 days
//   fast                    1 = divide by FAST_DIV instead of SLOW_DIV
//   down                    1 = count backwards
//   hold                    1 = freeze divider and date
//   load                    pulse: load load_month/load_day
//   load_month, load_day    binary date to load
//   alarm_month, alarm_day  binary alarm date (DATE_ALARM_EN only)
//   month_bcd, day_bcd      2-digit BCD date
//   doy_bcd                 3-digit BCD day of year
//   tick                    pulse in the cycle after the date steps
//   year_wrap               pulse with tick on Dec31<->Jan01
//   load_err                pulse after a rejected load
//   alarm_hit               pulse when the new date equals the alarm
module calendar_date_counter #(
  parameter int SLOW_DIV = 10_000_000,
  parameter int FAST_DIV = 2_000_000,
  parameter int DIV_W    = 24
) (
  input  logic        ADC_CLK_10,
  input  logic        rst_n,
  input  logic        leap,
  input  logic        fast,
  input  logic        down,
  input  logic        hold,
  input  logic        load,
  input  logic [3:0]  load_month,
  input  logic [4:0]  load_day,
  input  logic [3:0]  alarm_month,
  input  logic [4:0]  alarm_day,
  output logic [7:0]  month_bcd,
  output logic [7:0]  day_bcd,
  output logic [11:0] doy_bcd,
  output logic        tick,
  output logic        year_wrap,
  output logic        load_err,
  output logic        alarm_hit
);

  localparam logic [DIV_W-1:0] SLOW_MAX = DIV_W'(SLOW_DIV - 1);
  localparam logic [DIV_W-1:0] FAST_MAX = DIV_W'(FAST_DIV - 1);

  function automatic logic [4:0] days_in(
    input logic [3:0] m,
    input logic       lp
  );
    logic [4:0] d;
    case (m)
      4'd2:    d = lp ? 5'd29 : 5'd28;
      4'd4,
      4'd6,
      4'd9,
      4'd11:   d = 5'd30;
      default: d = 5'd31;
    endcase
    return d;
  endfunction

  // Days before the first of month m in a common year.
  function automatic logic [8:0] cum_days(
    input logic [3:0] m
  );
    logic [8:0] c;
    case (m)
      4'd2:    c = 9'd31;
      4'd3:    c = 9'd59;
      4'd4:    c = 9'd90;
      4'd5:    c = 9'd120;
      4'd6:    c = 9'd151;
      4'd7:    c = 9'd181;
      4'd8:    c = 9'd212;
      4'd9:    c = 9'd243;
      4'd10:   c = 9'd273;
      4'd11:   c = 9'd304;
      4'd12:   c = 9'd334;
      default: c = 9'd0;
    endcase
    return c;
  endfunction

  // Shift-add-3 binary to 3-digit BCD.
  function automatic logic [11:0] to_bcd(
    input logic [8:0] v
  );
    logic [20:0] s;
    s = {12'd0, v};
    for (int i = 0; i < 9; i++) begin
      if (s[12:9] >= 4'd5)
        s[12:9] = s[12:9] + 4'd3;
      if (s[16:13] >= 4'd5)
        s[16:13] = s[16:13] + 4'd3;
      if (s[20:17] >= 4'd5)
        s[20:17] = s[20:17] + 4'd3;
      s = s << 1;
    end
    return s[20:9];
  endfunction

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] cnt_n;
  logic [DIV_W-1:0] div_max;
  logic [3:0]       month;
  logic [3:0]       month_n;
  logic [4:0]       day;
  logic [4:0]       day_n;
  logic [8:0]       doy;
  logic [8:0]       doy_n;
  logic             term;
  logic             load_ok;
  logic             step;
  logic             wrap_n;
  logic             err_n;
  logic             alarm_n;
  logic [11:0]      m_bcd;
  logic [11:0]      d_bcd;
  logic [11:0]      y_bcd;

  assign div_max = fast ? FAST_MAX : SLOW_MAX;
  assign term    = div_cnt >= div_max;

  assign load_ok = (load_month >= 4'd1) &&
                   (load_month <= 4'd12) &&
                   (load_day >= 5'd1) &&
                   (load_day <= days_in(load_month, leap));

  always_comb begin
    cnt_n   = div_cnt;
    month_n = month;
    day_n   = day;
    doy_n   = doy;
    step    = 1'b0;
    wrap_n  = 1'b0;
    err_n   = 1'b0;
    if (load) begin
      if (load_ok) begin
        cnt_n   = '0;
        month_n = load_month;
        day_n   = load_day;
        doy_n   = cum_days(load_month) +
                  {4'd0, load_day} +
                  {8'd0, leap && (load_month > 4'd2)};
      end else begin
        err_n = 1'b1;
      end
    end else if (hold) begin
      cnt_n = div_cnt;
    end else if (term) begin
      cnt_n = '0;
      step  = 1'b1;
      if (!down) begin
        if (day < days_in(month, leap)) begin
          day_n = day + 5'd1;
          doy_n = doy + 9'd1;
        end else if (month == 4'd12) begin
          month_n = 4'd1;
          day_n   = 5'd1;
          doy_n   = 9'd1;
          wrap_n  = 1'b1;
        end else begin
          month_n = month + 4'd1;
          day_n   = 5'd1;
          doy_n   = doy + 9'd1;
        end
      end else begin
        if (day > 5'd1) begin
          day_n = day - 5'd1;
          doy_n = doy - 9'd1;
        end else if (month == 4'd1) begin
          month_n = 4'd12;
          day_n   = 5'd31;
          doy_n   = leap ? 9'd366 : 9'd365;
          wrap_n  = 1'b1;
        end else begin
          month_n = month - 4'd1;
          day_n   = days_in(month - 4'd1, leap);
          doy_n   = doy - 9'd1;
        end
      end
    end else begin
      cnt_n = div_cnt + DIV_W'(1);
    end
  end

`ifdef DATE_ALARM_EN
  assign alarm_n = (step || (load && load_ok)) &&
                   (month_n == alarm_month) &&
                   (day_n == alarm_day);
`else
  logic unused_alarm;
  assign unused_alarm = ^{alarm_month, alarm_day};
  assign alarm_n      = 1'b0;
`endif

  assign m_bcd = to_bcd({5'd0, month_n});
  assign d_bcd = to_bcd({4'd0, day_n});
  assign y_bcd = to_bcd(doy_n);

  always_ff @(posedge ADC_CLK_10 or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      month     <= 4'd1;
      day       <= 5'd1;
      doy       <= 9'd1;
      month_bcd <= 8'h01;
      day_bcd   <= 8'h01;
      doy_bcd   <= 12'h001;
      tick      <= 1'b0;
      year_wrap <= 1'b0;
      load_err  <= 1'b0;
      alarm_hit <= 1'b0;
    end else begin
      div_cnt   <= cnt_n;
      month     <= month_n;
      day       <= day_n;
      doy       <= doy_n;
      month_bcd <= m_bcd[7:0];
      day_bcd   <= d_bcd[7:0];
      doy_bcd   <= y_bcd;
      tick      <= step;
      year_wrap <= wrap_n;
      load_err  <= err_n;
      alarm_hit <= alarm_n;
    end
  end

endmodule

// File: tb/tb_calendar_date_counter.sv
// Directed bench for calendar_date_counter.
// Runs with SLOW_DIV=8, FAST_DIV=2.
module tb_calendar_date_counter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        leap;
  logic        fast;
  logic        down;
  logic        hold;
  logic        load;
  logic [3:0]  load_month;
  logic [4:0]  load_day;
  logic [3:0]  alarm_month;
  logic [4:0]  alarm_day;
  logic [7:0]  month_bcd;
  logic [7:0]  day_bcd;
  logic [11:0] doy_bcd;
  logic        tick;
  logic        year_wrap;
  logic        load_err;
  logic        alarm_hit;

  int n_chk  = 0;
  int n_fail = 0;
  int c;
  logic saw_tick;
  logic moved;

`ifdef DATE_ALARM_EN
  localparam logic ALM = 1'b1;
`else
  localparam logic ALM = 1'b0;
`endif

  always #5 clk = ~clk;

  calendar_date_counter #(
    .SLOW_DIV(8),
    .FAST_DIV(2),
    .DIV_W(4)
  ) dut (
    .ADC_CLK_10(clk),
    .rst_n(rst_n),
    .leap(leap),
    .fast(fast),
    .down(down),
    .hold(hold),
    .load(load),
    .load_month(load_month),
    .load_day(load_day),
    .alarm_month(alarm_month),
    .alarm_day(alarm_day),
    .month_bcd(month_bcd),
    .day_bcd(day_bcd),
    .doy_bcd(doy_bcd),
    .tick(tick),
    .year_wrap(year_wrap),
    .load_err(load_err),
    .alarm_hit(alarm_hit)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_date(
    input string       tag,
    input logic [7:0]  m,
    input logic [7:0]  d,
    input logic [11:0] y
  );
    chk({tag, "_month"}, {24'd0, month_bcd}, {24'd0, m});
    chk({tag, "_day"}, {24'd0, day_bcd}, {24'd0, d});
    chk({tag, "_doy"}, {20'd0, doy_bcd}, {20'd0, y});
  endtask

  task automatic wait_tick(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!tick && cnt < 40);
    chk("tick_seen", {31'd0, tick}, 32'd1);
  endtask

  task automatic do_load(
    input logic [3:0] m,
    input logic [4:0] d
  );
    load_month = m;
    load_day   = d;
    load       = 1'b1;
    @(negedge clk);
    load       = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    leap        = 1'b0;
    fast        = 1'b0;
    down        = 1'b0;
    hold        = 1'b0;
    load        = 1'b0;
    load_month  = 4'd1;
    load_day    = 5'd1;
    alarm_month = 4'd3;
    alarm_day   = 5'd3;
    repeat (2) @(negedge clk);
    chk_date("reset", 8'h01, 8'h01, 12'h001);
    chk("reset_tick", {31'd0, tick}, 32'd0);
    chk("reset_wrap", {31'd0, year_wrap}, 32'd0);
    chk("reset_err", {31'd0, load_err}, 32'd0);
    chk("reset_alarm", {31'd0, alarm_hit}, 32'd0);
    rst_n = 1'b1;

    // T1: full common year
    wait_tick(c);
    chk("first_latency", c, 32'd8);
    chk_date("t1_first", 8'h01, 8'h02, 12'h002);
    for (int i = 0; i < 363; i++)
      wait_tick(c);
    chk_date("t1_dec31", 8'h12, 8'h31, 12'h365);
    chk("t1_nowrap", {31'd0, year_wrap}, 32'd0);
    wait_tick(c);
    chk_date("t1_jan01", 8'h01, 8'h01, 12'h001);
    chk("t1_wrap", {31'd0, year_wrap}, 32'd1);
    @(negedge clk);
    chk("t1_wrap_end", {31'd0, year_wrap}, 32'd0);

    // T2: leap February
    leap = 1'b1;
    do_load(4'd2, 5'd28);
    chk_date("t2_load", 8'h02, 8'h28, 12'h059);
    chk("t2_load_notick", {31'd0, tick}, 32'd0);
    wait_tick(c);
    chk_date("t2_feb29", 8'h02, 8'h29, 12'h060);
    wait_tick(c);
    chk_date("t2_mar01", 8'h03, 8'h01, 12'h061);
    leap = 1'b0;
    do_load(4'd2, 5'd28);
    wait_tick(c);
    chk_date("t2_common", 8'h03, 8'h01, 12'h060);

    // T3: backwards across new year
    leap = 1'b1;
    do_load(4'd1, 5'd1);
    down = 1'b1;
    wait_tick(c);
    chk_date("t3_dec31", 8'h12, 8'h31, 12'h366);
    chk("t3_wrap", {31'd0, year_wrap}, 32'd1);
    wait_tick(c);
    chk_date("t3_dec30", 8'h12, 8'h30, 12'h365);
    chk("t3_nowrap", {31'd0, year_wrap}, 32'd0);

    // T4: fast rate and hold
    down = 1'b0;
    leap = 1'b0;
    fast = 1'b1;
    do_load(4'd3, 5'd10);
    chk_date("t4_load", 8'h03, 8'h10, 12'h069);
    wait_tick(c);
    chk("t4_fast_lat", c, 32'd2);
    wait_tick(c);
    chk("t4_fast_per", c, 32'd2);
    chk_date("t4_mar12", 8'h03, 8'h12, 12'h071);
    hold     = 1'b1;
    saw_tick = 1'b0;
    moved    = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tick)
        saw_tick = 1'b1;
      if (day_bcd !== 8'h12 || doy_bcd !== 12'h071)
        moved = 1'b1;
    end
    chk("t4_hold_tick", {31'd0, saw_tick}, 32'd0);
    chk("t4_hold_moved", {31'd0, moved}, 32'd0);
    hold = 1'b0;
    wait_tick(c);
    chk("t4_resume", c, 32'd2);
    chk_date("t4_mar13", 8'h03, 8'h13, 12'h072);

    // T5: rejected loads, load beats a tick
    hold = 1'b1;
    fast = 1'b0;
    do_load(4'd4, 5'd31);
    chk("t5_apr31_err", {31'd0, load_err}, 32'd1);
    chk_date("t5_apr31", 8'h03, 8'h13, 12'h072);
    @(negedge clk);
    chk("t5_err_end", {31'd0, load_err}, 32'd0);
    do_load(4'd2, 5'd29);
    chk("t5_feb29_err", {31'd0, load_err}, 32'd1);
    chk_date("t5_feb29", 8'h03, 8'h13, 12'h072);
    hold = 1'b0;
    wait_tick(c);
    chk("t5_slow_lat", c, 32'd8);
    chk_date("t5_mar14", 8'h03, 8'h14, 12'h073);
    repeat (7) @(negedge clk);
    do_load(4'd6, 5'd15);
    chk("t5_load_notick", {31'd0, tick}, 32'd0);
    chk("t5_load_noerr", {31'd0, load_err}, 32'd0);
    chk_date("t5_jun15", 8'h06, 8'h15, 12'h166);
    wait_tick(c);
    chk("t5_div_clr", c, 32'd8);
    chk_date("t5_jun16", 8'h06, 8'h16, 12'h167);

    // T6: alarm and asynchronous reset
    do_load(4'd3, 5'd1);
    chk("t6_load_noalm", {31'd0, alarm_hit}, 32'd0);
    wait_tick(c);
    chk("t6_tick1_alm", {31'd0, alarm_hit}, 32'd0);
    wait_tick(c);
    chk_date("t6_mar03", 8'h03, 8'h03, 12'h062);
    chk("t6_tick2_alm", {31'd0, alarm_hit}, {31'd0, ALM});
    @(negedge clk);
    chk("t6_alm_end", {31'd0, alarm_hit}, 32'd0);
    do_load(4'd3, 5'd3);
    chk("t6_load_alm", {31'd0, alarm_hit}, {31'd0, ALM});
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_date("t6_async_rst", 8'h01, 8'h01, 12'h001);
    chk("t6_rst_tick", {31'd0, tick}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_tick(c);
    chk("t6_rst_lat", c, 32'd8);
    chk_date("t6_jan02", 8'h01, 8'h02, 12'h002);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
